regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between the pipeline WB stage and
//  the SRAM/cache load-return path. WB writes are buffered in a small FIFO; load

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_fifo.sv | 88 ++++++++
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter slice.
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_NREG       = 15;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam int PC_IDX         = 15;

    // Which requester owned the write port most recently
    typedef enum logic {
        GNT_WB  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO buffering WB-stage writes; exposes per-entry dest/valid
// so the top level can build the pending-write mask.
module regfile_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [ADDR_W-1:0]              push_dest_i,
    input  logic [DATA_W-1:0]              push_data_i,
    input  logic                           pop_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [ADDR_W-1:0]              head_dest_o,
    output logic [DATA_W-1:0]              head_data_o,
    output logic [DEPTH-1:0]               ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_dest_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                         do_push;
    logic                         do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_dest_o = dest_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign ent_valid_o = valid_q;
    assign ent_dest_o  = dest_q;

    // Next storage/pointer state; push and pop never touch the same slot because
    // push is blocked when full and pop is blocked when empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        dest_d   = dest_q;
        data_d   = data_q;
        if (do_push) begin
            dest_d[wr_ptr_q]  = push_dest_i;
            data_d[wr_ptr_q]  = push_data_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO state registers; reset discards all buffered writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between buffered
// WB-stage writes and load returns, with a registered write stage and a
// pending-write mask for the hazard unit.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NREG       = DEF_NREG,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_dest_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              wb_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_dest_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ready_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_dest_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic [NREG-1:0]   pend_mask_o
);

    // One-hot of a register index; indices outside the file (PC) give zero
    function automatic logic [NREG-1:0] reg_bit(input logic [ADDR_W-1:0] dest);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int r = 0; r < NREG; r++) begin
            oh[r] = (32'(dest) == 32'(r));
        end
        return oh;
    endfunction

    logic                             fifo_full;
    logic                             fifo_empty;
    logic [ADDR_W-1:0]                head_dest;
    logic [DATA_W-1:0]                head_data;
    logic [FIFO_DEPTH-1:0]            ent_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_dest;

    grant_e            last_grant_q, last_grant_d;
    logic              grant_wb, grant_mem;
    logic [ADDR_W-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREG-1:0]   pend_mask;

    assign wb_ready_o  = !fifo_full;
    assign mem_ready_o = grant_mem;
    assign rf_we_o     = rf_we_q;
    assign rf_dest_o   = rf_dest_q;
    assign rf_data_o   = rf_data_q;
    assign pend_mask_o = pend_mask;

    regfile_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wb_valid_i && wb_ready_o),
        .push_dest_i (wb_dest_i),
        .push_data_i (wb_data_i),
        .pop_i       (grant_wb),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_dest_o (head_dest),
        .head_data_o (head_data),
        .ent_valid_o (ent_valid),
        .ent_dest_o  (ent_dest)
    );

    // Round-robin state register; starting at MEM lets WB win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Round-robin next state: remember whoever was granted, hold otherwise
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_wb) begin
            last_grant_d = GNT_WB;
        end else if (grant_mem) begin
            last_grant_d = GNT_MEM;
        end
    end

    // Grant decode: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        grant_wb  = 1'b0;
        grant_mem = 1'b0;
        if (!fifo_empty && mem_valid_i) begin
            if (last_grant_q == GNT_MEM) begin
                grant_wb = 1'b1;
            end else begin
                grant_mem = 1'b1;
            end
        end else begin
            grant_wb  = !fifo_empty;
            grant_mem = mem_valid_i;
        end
    end

    // Select the winning write and decide whether it actually reaches the file
    always_comb begin
        sel_dest  = grant_mem ? mem_dest_i : head_dest;
        sel_data  = grant_mem ? mem_data_i : head_data;
        rf_we_d   = (grant_wb || grant_mem) && (|reg_bit(sel_dest));
        rf_dest_d = rf_dest_q;
        rf_data_d = rf_data_q;
        if (grant_wb || grant_mem) begin
            rf_dest_d = sel_dest;
            rf_data_d = sel_data;
        end
    end

    // Registered write stage; reset drops any write that was in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_dest_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_dest_q <= rf_dest_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Pending mask covers buffered WB writes, the output stage and a waiting load
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_mask = pend_mask | reg_bit(ent_dest[i]);
            end
        end
        if (rf_we_q) begin
            pend_mask = pend_mask | reg_bit(rf_dest_q);
        end
        if (mem_valid_i) begin
            pend_mask = pend_mask | reg_bit(mem_dest_i);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: each cycle inputs are driven 1ns after
// the rising edge and outputs are compared 2ns after the rising edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid_i;
    logic [3:0]  wb_dest_i;
    logic [31:0] wb_data_i;
    logic        wb_ready_o;
    logic        mem_valid_i;
    logic [3:0]  mem_dest_i;
    logic [31:0] mem_data_i;
    logic        mem_ready_o;
    logic        rf_we_o;
    logic [3:0]  rf_dest_o;
    logic [31:0] rf_data_o;
    logic [14:0] pend_mask_o;

    int n_checks;
    int n_fail;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid_i  (wb_valid_i),
        .wb_dest_i   (wb_dest_i),
        .wb_data_i   (wb_data_i),
        .wb_ready_o  (wb_ready_o),
        .mem_valid_i (mem_valid_i),
        .mem_dest_i  (mem_dest_i),
        .mem_data_i  (mem_data_i),
        .mem_ready_o (mem_ready_o),
        .rf_we_o     (rf_we_o),
        .rf_dest_o   (rf_dest_o),
        .rf_data_o   (rf_data_o),
        .pend_mask_o (pend_mask_o)
    );

    // Free-running clock, 10ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic wv, input logic [3:0] wd, input logic [31:0] wdat,
                                 input logic mv, input logic [3:0] md, input logic [31:0] mdat);
        wb_valid_i  = wv;
        wb_dest_i   = wd;
        wb_data_i   = wdat;
        mem_valid_i = mv;
        mem_dest_i  = md;
        mem_data_i  = mdat;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic [3:0] dest, input logic [31:0] data);
        checkOutput({tag, "_we"}, 64'(rf_we_o), 64'd1);
        checkOutput({tag, "_dest"}, 64'(rf_dest_o), 64'(dest));
        checkOutput({tag, "_data"}, 64'(rf_data_o), 64'(data));
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        // ---- Reset state, then WB-only write of R3 ----
        resetDut();
        settle();
        checkOutput("rst_we", 64'(rf_we_o), 64'd0);
        checkOutput("rst_dest", 64'(rf_dest_o), 64'd0);
        checkOutput("rst_data", 64'(rf_data_o), 64'd0);
        checkOutput("rst_pend", 64'(pend_mask_o), 64'd0);
        checkOutput("rst_wb_ready", 64'(wb_ready_o), 64'd1);
        checkOutput("rst_mem_ready", 64'(mem_ready_o), 64'd0);
        applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t1_c0_pend", 64'(pend_mask_o), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t1_c1_we", 64'(rf_we_o), 64'd0);
        checkOutput("t1_c1_pend", 64'(pend_mask_o), 64'h8);
        nextCycle();
        settle();
        checkWrite("t1_c2", 4'd3, 32'hDEADBEEF);
        checkOutput("t1_c2_pend", 64'(pend_mask_o), 64'h8);
        nextCycle();
        settle();
        checkOutput("t1_c3_we", 64'(rf_we_o), 64'd0);
        checkOutput("t1_c3_pend", 64'(pend_mask_o), 64'h0);
        checkOutput("t1_c3_dest_hold", 64'(rf_dest_o), 64'd3);

        // ---- Back-pressure: last grant was WB, load path held busy ----
        nextCycle();
        applyStimulus(1'b1, 4'd1, 32'h101, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t4_c0_wb_ready", 64'(wb_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 4'd2, 32'h202, 1'b1, 4'd9, 32'h909);
        settle();
        checkOutput("t4_c1_mem_ready", 64'(mem_ready_o), 64'd1);
        checkOutput("t4_c1_wb_ready", 64'(wb_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 4'd3, 32'h303, 1'b1, 4'd10, 32'hA0A);
        settle();
        checkOutput("t4_c2_wb_ready", 64'(wb_ready_o), 64'd0);
        checkOutput("t4_c2_mem_ready", 64'(mem_ready_o), 64'd0);
        checkWrite("t4_c2", 4'd9, 32'h909);
        nextCycle();
        settle();
        checkOutput("t4_c3_wb_ready", 64'(wb_ready_o), 64'd1);
        checkOutput("t4_c3_mem_ready", 64'(mem_ready_o), 64'd1);
        checkWrite("t4_c3", 4'd1, 32'h101);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd11, 32'hB0B);
        settle();
        checkOutput("t4_c4_wb_ready", 64'(wb_ready_o), 64'd0);
        checkOutput("t4_c4_mem_ready", 64'(mem_ready_o), 64'd0);
        checkOutput("t4_c4_pend", 64'(pend_mask_o), 64'h0C0C);
        checkWrite("t4_c4", 4'd10, 32'hA0A);
        nextCycle();
        settle();
        checkOutput("t4_c5_mem_ready", 64'(mem_ready_o), 64'd1);
        checkWrite("t4_c5", 4'd2, 32'h202);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkWrite("t4_c6", 4'd11, 32'hB0B);
        nextCycle();
        settle();
        checkWrite("t4_c7", 4'd3, 32'h303);
        nextCycle();
        settle();
        checkOutput("t4_c8_we", 64'(rf_we_o), 64'd0);

        // ---- Load return only ----
        resetDut();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h12345678);
        settle();
        checkOutput("t2_c0_mem_ready", 64'(mem_ready_o), 64'd1);
        checkOutput("t2_c0_pend", 64'(pend_mask_o), 64'h20);
        checkOutput("t2_c0_we", 64'(rf_we_o), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkWrite("t2_c1", 4'd5, 32'h12345678);
        checkOutput("t2_c1_mem_ready", 64'(mem_ready_o), 64'd0);

        // ---- Contention: alternating grants starting with WB ----
        resetDut();
        applyStimulus(1'b1, 4'd1, 32'h11, 1'b0, 4'd0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd2, 32'h22, 1'b1, 4'd7, 32'h77);
        settle();
        checkOutput("t3_c1_mem_ready", 64'(mem_ready_o), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd3, 32'h33, 1'b1, 4'd7, 32'h77);
        settle();
        checkOutput("t3_c2_mem_ready", 64'(mem_ready_o), 64'd1);
        checkOutput("t3_c2_wb_ready", 64'(wb_ready_o), 64'd1);
        checkWrite("t3_c2", 4'd1, 32'h11);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 32'h88);
        settle();
        checkOutput("t3_c3_wb_ready", 64'(wb_ready_o), 64'd0);
        checkOutput("t3_c3_mem_ready", 64'(mem_ready_o), 64'd0);
        checkOutput("t3_c3_pend", 64'(pend_mask_o), 64'h018C);
        checkWrite("t3_c3", 4'd7, 32'h77);
        nextCycle();
        settle();
        checkOutput("t3_c4_mem_ready", 64'(mem_ready_o), 64'd1);
        checkWrite("t3_c4", 4'd2, 32'h22);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkWrite("t3_c5", 4'd8, 32'h88);
        nextCycle();
        settle();
        checkWrite("t3_c6", 4'd3, 32'h33);
        nextCycle();
        settle();
        checkOutput("t3_c7_we", 64'(rf_we_o), 64'd0);

        // ---- PC destination is consumed but never written ----
        nextCycle();
        applyStimulus(1'b1, 4'd15, 32'hF0F0, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t5_c0_pend", 64'(pend_mask_o), 64'h0);
        nextCycle();
        applyStimulus(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t5_c1_pend", 64'(pend_mask_o), 64'h0);
        checkOutput("t5_c1_wb_ready", 64'(wb_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t5_c2_we", 64'(rf_we_o), 64'd0);
        checkOutput("t5_c2_pend", 64'(pend_mask_o), 64'h10);
        nextCycle();
        settle();
        checkWrite("t5_c3", 4'd4, 32'h44);

        // ---- Async reset with FIFO full and a write in flight ----
        nextCycle();
        applyStimulus(1'b1, 4'd1, 32'h1, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t6_c0_we", 64'(rf_we_o), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd2, 32'h2, 1'b1, 4'd9, 32'h9);
        settle();
        checkOutput("t6_c1_mem_ready", 64'(mem_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        settle();
        checkOutput("t6_c2_wb_ready", 64'(wb_ready_o), 64'd0);
        checkWrite("t6_c2", 4'd9, 32'h9);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_we", 64'(rf_we_o), 64'd0);
        checkOutput("t6_rst_dest", 64'(rf_dest_o), 64'd0);
        checkOutput("t6_rst_data", 64'(rf_data_o), 64'd0);
        checkOutput("t6_rst_pend", 64'(pend_mask_o), 64'd0);
        checkOutput("t6_rst_wb_ready", 64'(wb_ready_o), 64'd1);
        checkOutput("t6_rst_mem_ready", 64'(mem_ready_o), 64'd0);
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            settle();
            checkOutput("t6_post_we", 64'(rf_we_o), 64'd0);
            checkOutput("t6_post_pend", 64'(pend_mask_o), 64'd0);
            checkOutput("t6_post_wb_ready", 64'(wb_ready_o), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
